// File: rtl/mlt3_pkg.sv
// Shared types, line-level constants and the single-bit MLT-3/NRZI step function.
package mlt3_pkg;

  localparam logic [1:0] LEVEL_0 = 2'b00;
  localparam logic [1:0] LEVEL_P = 2'b10;
  localparam logic [1:0] LEVEL_N = 2'b01;

  typedef enum logic [1:0] {
    ZERO_UP = 2'd0,
    POS     = 2'd1,
    ZERO_DN = 2'd2,
    NEG     = 2'd3
  } state_t;

  typedef enum logic {
    MODE_MLT3 = 1'b0,
    MODE_NRZI = 1'b1
  } mode_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] level;
  } step_t;

  // One serial bit step: returns the state after the bit and the level it emits.
  // In NRZI only POS/NEG are meaningful; anything other than POS counts as NEG.
  function automatic step_t encode_step(state_t cur, logic data_bit, mode_t mode);
    step_t r;
    r.state = cur;
    r.level = LEVEL_0;
    if (mode == MODE_NRZI) begin
      if (data_bit) r.state = (cur == POS) ? NEG : POS;
      else          r.state = (cur == POS) ? POS : NEG;
    end else if (data_bit) begin
      case (cur)
        ZERO_UP: r.state = POS;
        POS:     r.state = ZERO_DN;
        ZERO_DN: r.state = NEG;
        default: r.state = ZERO_UP;
      endcase
    end
    case (r.state)
      POS:     r.level = LEVEL_P;
      NEG:     r.level = LEVEL_N;
      default: r.level = LEVEL_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mlt3_lane.sv
// One encoder lane: state register, unrolled bit-serial encoder, polarity swap, output flops.
module mlt3_lane
  import mlt3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  squelch,
  input  mode_t                 mode,
  input  logic                  restart,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  swap,
  output logic [DATA_WIDTH-1:0] out_p,
  output logic [DATA_WIDTH-1:0] out_n
);

  state_t                state_q;
  state_t                start_state;
  state_t                end_state;
  state_t                walk;
  step_t                 stp;
  logic [DATA_WIDTH-1:0] enc_p;
  logic [DATA_WIDTH-1:0] enc_n;

  // Starting state for this beat: reinitialise on a mode change, and fold ZERO_* onto NEG for NRZI.
  always_comb begin
    start_state = state_q;
    if (restart)
      start_state = (mode == MODE_NRZI) ? NEG : ZERO_UP;
    else if ((mode == MODE_NRZI) && (state_q != POS))
      start_state = NEG;
  end

  // Unrolled chain of DATA_WIDTH steps, bit 0 first; swap applied to the emitted level only.
  always_comb begin
    walk  = start_state;
    stp   = '0;
    enc_p = '0;
    enc_n = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      stp  = encode_step(walk, data[i], mode);
      walk = stp.state;
      if (swap) {enc_p[i], enc_n[i]} = {stp.level[0], stp.level[1]};
      else      {enc_p[i], enc_n[i]} = stp.level;
    end
    end_state = walk;
  end

  // Lane state and registered outputs; squelch overrides any incoming beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ZERO_UP;
      out_p   <= '0;
      out_n   <= '0;
    end else if (squelch) begin
      state_q <= ZERO_UP;
      out_p   <= '0;
      out_n   <= '0;
    end else if (load) begin
      state_q <= end_state;
      out_p   <= enc_p;
      out_n   <= enc_n;
    end
  end

endmodule

// File: rtl/mlt3_line_encoder.sv
// Multi-lane MLT-3 / NRZI line encoder: shared handshake and stored mode, one mlt3_lane per lane.
module mlt3_line_encoder
  import mlt3_pkg::*;
#(
  parameter int unsigned LANES      = 1,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        mode,
  input  logic                        tx_enable,
  input  logic [LANES-1:0]            polarity_swap,
  output logic                        out_valid,
  output logic [LANES*DATA_WIDTH-1:0] out_p,
  output logic [LANES*DATA_WIDTH-1:0] out_n
);

  mode_t mode_in;
  mode_t mode_q;
  logic  accept;
  logic  restart;

  // Beat acceptance (tx_enable dominates) and mode-change detection against the last accepted beat.
  always_comb begin
    mode_in = mode_t'(mode);
    accept  = in_valid & tx_enable;
    restart = (mode_in != mode_q);
  end

  // Shared output qualifier and the mode of the last accepted beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q    <= MODE_MLT3;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) mode_q <= mode_in;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mlt3_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .load    (accept),
      .squelch (~tx_enable),
      .mode    (mode_in),
      .restart (restart),
      .data    (in_data[l*DATA_WIDTH +: DATA_WIDTH]),
      .swap    (polarity_swap[l]),
      .out_p   (out_p[l*DATA_WIDTH +: DATA_WIDTH]),
      .out_n   (out_n[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_mlt3_line_encoder.sv
// Self-checking bench: directed cases plus random beats against a counting-based line model.
module tb_mlt3_line_encoder;

  localparam int L  = 2;
  localparam int DW = 4;
  localparam int W  = L * DW;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         mode = 1'b0;
  logic         tx_enable = 1'b1;
  logic [L-1:0] polarity_swap = '0;
  logic         out_valid;
  logic [W-1:0] out_p;
  logic [W-1:0] out_n;

  int checks = 0;
  int errors = 0;

  // Reference model: MLT-3 as a count of ones modulo 4, NRZI as a signed level.
  int           m_ones [L];
  int           m_lvl  [L];
  logic         m_mode;
  logic [W-1:0] exp_p;
  logic [W-1:0] exp_n;
  logic         exp_valid;

  mlt3_line_encoder #(
    .LANES(L),
    .DATA_WIDTH(DW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .mode          (mode),
    .tx_enable     (tx_enable),
    .polarity_swap (polarity_swap),
    .out_valid     (out_valid),
    .out_p         (out_p),
    .out_n         (out_n)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear_lanes();
    for (int l = 0; l < L; l++) begin
      m_ones[l] = 0;
      m_lvl[l]  = -1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    model_clear_lanes();
    m_mode    = 1'b0;
    exp_p     = '0;
    exp_n     = '0;
    exp_valid = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'(exp_valid));
    check("rst_p", 64'(out_p), 64'(exp_p));
    check("rst_n", 64'(out_n), 64'(exp_n));
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic beat(input logic v, input logic [W-1:0] data, input logic md, input logic en);
    int lv;
    in_valid  = v;
    in_data   = data;
    mode      = md;
    tx_enable = en;
    if (!en) begin
      model_clear_lanes();
      exp_p     = '0;
      exp_n     = '0;
      exp_valid = 1'b0;
    end else if (v) begin
      if (md != m_mode) model_clear_lanes();
      m_mode = md;
      for (int l = 0; l < L; l++) begin
        for (int b = 0; b < DW; b++) begin
          if (md == 1'b0) begin
            if (data[l*DW+b]) m_ones[l] = (m_ones[l] + 1) % 4;
            lv = (m_ones[l] == 1) ? 1 : (m_ones[l] == 3) ? -1 : 0;
          end else begin
            if (data[l*DW+b]) m_lvl[l] = -m_lvl[l];
            lv = m_lvl[l];
          end
          exp_p[l*DW+b] = polarity_swap[l] ? (lv < 0) : (lv > 0);
          exp_n[l*DW+b] = polarity_swap[l] ? (lv > 0) : (lv < 0);
        end
      end
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("out_p", 64'(out_p), 64'(exp_p));
    check("out_n", 64'(out_n), 64'(exp_n));
    check("p_and_n", 64'(out_p & out_n), 64'd0);
  endtask

  initial begin
    m_mode    = 1'b0;
    exp_p     = '0;
    exp_n     = '0;
    exp_valid = 1'b0;
    model_clear_lanes();

    // Reset state and MLT-3 on all-ones beats
    do_reset();
    beat(1'b1, {2{4'b1111}}, 1'b0, 1'b1);
    check("ones1_p", 64'(out_p[3:0]), 64'h1);
    check("ones1_n", 64'(out_n[3:0]), 64'h4);
    check("ones1_v", 64'(out_valid), 64'h1);
    beat(1'b1, {2{4'b1111}}, 1'b0, 1'b1);
    check("ones2_p", 64'(out_p[3:0]), 64'h1);
    check("ones2_n", 64'(out_n[3:0]), 64'h4);

    // Holding zeros, then carry state across beats
    do_reset();
    beat(1'b1, {2{4'b0101}}, 1'b0, 1'b1);
    check("b0101_p", 64'(out_p[3:0]), 64'h3);
    check("b0101_n", 64'(out_n[3:0]), 64'h0);
    beat(1'b1, {2{4'b0001}}, 1'b0, 1'b1);
    check("b0001_p", 64'(out_p[3:0]), 64'h0);
    check("b0001_n", 64'(out_n[3:0]), 64'hF);

    // NRZI from reset, then mode switch back to MLT-3
    do_reset();
    beat(1'b1, {2{4'b1011}}, 1'b1, 1'b1);
    check("nrzi_p", 64'(out_p[3:0]), 64'h9);
    check("nrzi_n", 64'(out_n[3:0]), 64'h6);
    beat(1'b1, {2{4'b0001}}, 1'b0, 1'b1);
    check("sw_p", 64'(out_p[3:0]), 64'hF);
    check("sw_n", 64'(out_n[3:0]), 64'h0);

    // Valid gap: outputs hold, out_valid low, then resume from POS
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, {2{4'b1111}}, 1'b0, 1'b1);
      check("gap_p", 64'(out_p[3:0]), 64'hF);
      check("gap_v", 64'(out_valid), 64'h0);
    end
    beat(1'b1, {2{4'b0001}}, 1'b0, 1'b1);
    check("resume_p", 64'(out_p[3:0]), 64'h0);
    check("resume_n", 64'(out_n[3:0]), 64'h0);

    // Squelch for one cycle, then restart from ZERO_UP
    beat(1'b1, {2{4'b0001}}, 1'b0, 1'b1);
    beat(1'b1, {2{4'b0001}}, 1'b0, 1'b0);
    check("sq_p", 64'(out_p), 64'h0);
    check("sq_n", 64'(out_n), 64'h0);
    check("sq_v", 64'(out_valid), 64'h0);
    beat(1'b1, {2{4'b0001}}, 1'b0, 1'b1);
    check("sq_after_p", 64'(out_p[3:0]), 64'hF);

    // Per-lane polarity swap
    do_reset();
    polarity_swap = 2'b10;
    beat(1'b1, {2{4'b0001}}, 1'b0, 1'b1);
    check("swap_l0_p", 64'(out_p[3:0]), 64'hF);
    check("swap_l1_n", 64'(out_n[7:4]), 64'hF);
    check("swap_l1_p", 64'(out_p[7:4]), 64'h0);

    // Random beats
    begin
      logic md;
      md = 1'b0;
      for (int i = 0; i < 10000; i++) begin
        if ((i % 500) == 0) polarity_swap = L'($urandom);
        if ($urandom_range(0, 19) == 0) md = ~md;
        if ($urandom_range(0, 1999) == 0) begin
          do_reset();
        end
        beat($urandom_range(0, 9) < 8, W'($urandom), md, $urandom_range(0, 24) != 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
